cdf_pipeline: RTL and testbench

CDF_PIPELINE -- requirements
Module: cdf_pipeline

---
 rtl/cdf_pipeline_pkg.sv | 38 +++
 rtl/cdf_accum.sv | 66 ++++++
 rtl/cdf_pipeline.sv | 130 +++++++++++++
 tb/tb_cdf_pipeline.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/cdf_pipeline_pkg.sv
// rtl/cdf_pipeline_pkg.sv - shared constants, state encoding and helpers for the histogram-equalizer CDF stage
package cdf_pipeline_pkg;

   localparam int          NUM_BINS_DEFAULT  = 256;
   localparam logic [15:0] VALID_TAG_DEFAULT = 16'hAAAA;

   // Scratchpad geometry: 16-bit addresses, bank bit at [8], bin index in [7:0].
   localparam int ADDR_W     = 16;
   localparam int BIN_ADDR_W = 8;
   localparam int ADDR_PAD_W = ADDR_W - BIN_ADDR_W - 1;
   localparam int DATA_W     = 128;
   localparam int CUM_W      = 16;

   // FSM encoding.
   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_READ  = 2'd1;
   localparam logic [1:0] ST_DRAIN = 2'd2;
   localparam logic [1:0] ST_DONE  = 2'd3;

   // One read in flight: set in the issue cycle, consumed when the data returns.
   typedef struct packed {
      logic                  valid;
      logic                  last;
      logic [BIN_ADDR_W-1:0] bin;
   } rd_stage_t;

   // A bin only contributes when its upper half carries the initialisation tag.
   function automatic logic [CUM_W-1:0] bin_count(input logic [31:0] low_word,
                                                  input logic [15:0] tag);
      return (low_word[31:16] == tag) ? low_word[15:0] : '0;
   endfunction

   function automatic logic [ADDR_W-1:0] scratch_addr(input logic bank,
                                                      input logic [BIN_ADDR_W-1:0] bin);
      return {{ADDR_PAD_W{1'b0}}, bank, bin};
   endfunction

endpackage

// File: rtl/cdf_accum.sv
// rtl/cdf_accum.sv - running 16-bit cumulative sum with first-non-zero and final-value capture
module cdf_accum
   import cdf_pipeline_pkg::*;
#(
   parameter logic [15:0] VALID_TAG = VALID_TAG_DEFAULT
)(
   input  logic             clock,
   input  logic             rst,
   input  logic             clear_i,
   input  logic             valid_i,
   input  logic             last_i,
   input  logic [31:0]      word_i,
   output logic [CUM_W-1:0] cum_o,
   output logic [CUM_W-1:0] cdf_min_o,
   output logic [CUM_W-1:0] pixel_total_o
);

   logic [CUM_W-1:0] cum_q, cum_d;
   logic [CUM_W-1:0] min_q, min_d;
   logic [CUM_W-1:0] total_q, total_d;
   logic             found_q, found_d;

   // Next-state: clear on run start, otherwise fold in one bin per returned word.
   always_comb begin
      cum_d   = cum_q;
      min_d   = min_q;
      total_d = total_q;
      found_d = found_q;
      if (clear_i) begin
         cum_d   = '0;
         min_d   = '0;
         total_d = '0;
         found_d = 1'b0;
      end else if (valid_i) begin
         // Wraps modulo 2^16 by construction of the 16-bit add.
         cum_d = cum_q + bin_count(word_i, VALID_TAG);
         if (!found_q && (cum_d != '0)) begin
            min_d   = cum_d;
            found_d = 1'b1;
         end
         if (last_i) begin
            total_d = cum_d;
         end
      end
   end

   // State registers.
   always_ff @(posedge clock or posedge rst) begin
      if (rst) begin
         cum_q   <= '0;
         min_q   <= '0;
         total_q <= '0;
         found_q <= 1'b0;
      end else begin
         cum_q   <= cum_d;
         min_q   <= min_d;
         total_q <= total_d;
         found_q <= found_d;
      end
   end

   assign cum_o         = cum_q;
   assign cdf_min_o     = min_q;
   assign pixel_total_o = total_q;

endmodule

// File: rtl/cdf_pipeline.sv
// rtl/cdf_pipeline.sv - scans histogram bins from m2, writes the running CDF to m3
module cdf_pipeline
   import cdf_pipeline_pkg::*;
#(
   parameter int          NUM_BINS  = NUM_BINS_DEFAULT,
   parameter logic [15:0] VALID_TAG = VALID_TAG_DEFAULT
)(
   input  logic              clock,
   input  logic              rst,
   input  logic              start,
   input  logic              inputBaseOffset,
   output logic [ADDR_W-1:0] m2ReadAddr,
   input  logic [DATA_W-1:0] m2ReadVal,
   output logic [ADDR_W-1:0] m3WriteAddr,
   output logic [DATA_W-1:0] m3WriteVal,
   output logic              m3WE,
   output logic [CUM_W-1:0]  cdfMin,
   output logic [CUM_W-1:0]  pixelTotal,
   output logic              done
);

   localparam int                 BIN_W    = (NUM_BINS > 1) ? $clog2(NUM_BINS) : 1;
   localparam logic [BIN_W-1:0]   LAST_BIN = BIN_W'(NUM_BINS - 1);

   logic [1:0]            state_q, state_d;
   logic [BIN_W-1:0]      bin_q, bin_d;
   logic                  bank_q, bank_d;
   rd_stage_t             rd_q, rd_d;
   logic                  we_q, we_last_q;
   logic [ADDR_W-1:0]     waddr_q;
   logic                  run_clear;
   logic [BIN_ADDR_W-1:0] bin_addr;
   logic [CUM_W-1:0]      cum;
   logic                  unused_hi;

   assign bin_addr  = BIN_ADDR_W'(bin_q);
   // Only the low 32 bits of a histogram word carry tag and count.
   assign unused_hi = ^m2ReadVal[DATA_W-1:32];

   // FSM next-state and read-issue counter.
   always_comb begin
      state_d   = state_q;
      bin_d     = bin_q;
      bank_d    = bank_q;
      run_clear = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (start) begin
               state_d   = ST_READ;
               bin_d     = '0;
               bank_d    = inputBaseOffset;
               run_clear = 1'b1;
            end
         end
         ST_READ: begin
            if (bin_q == LAST_BIN) begin
               state_d = ST_DRAIN;
            end else begin
               bin_d = bin_q + BIN_W'(1);
            end
         end
         ST_DRAIN: begin
            // The final write is on the outputs this cycle.
            if (we_q && we_last_q) begin
               state_d = ST_DONE;
            end
         end
         ST_DONE: begin
            if (!start) begin
               state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // Tag each issued address so the returning word can be matched to its bin.
   always_comb begin
      rd_d       = '0;
      rd_d.valid = (state_q == ST_READ);
      rd_d.last  = (bin_q == LAST_BIN);
      rd_d.bin   = bin_addr;
   end

   // Control, read-tracking and write-stage registers.
   always_ff @(posedge clock or posedge rst) begin
      if (rst) begin
         state_q   <= ST_IDLE;
         bin_q     <= '0;
         bank_q    <= 1'b0;
         rd_q      <= '0;
         we_q      <= 1'b0;
         we_last_q <= 1'b0;
         waddr_q   <= '0;
      end else begin
         state_q   <= state_d;
         bin_q     <= bin_d;
         bank_q    <= bank_d;
         rd_q      <= rd_d;
         we_q      <= rd_q.valid;
         we_last_q <= rd_q.valid & rd_q.last;
         if (rd_q.valid) begin
            waddr_q <= scratch_addr(bank_q, rd_q.bin);
         end
      end
   end

   cdf_accum #(
      .VALID_TAG (VALID_TAG)
   ) u_accum (
      .clock         (clock),
      .rst           (rst),
      .clear_i       (run_clear),
      .valid_i       (rd_q.valid),
      .last_i        (rd_q.last),
      .word_i        (m2ReadVal[31:0]),
      .cum_o         (cum),
      .cdf_min_o     (cdfMin),
      .pixel_total_o (pixelTotal)
   );

   assign m2ReadAddr  = scratch_addr(bank_q, bin_addr);
   assign m3WriteAddr = waddr_q;
   // The accumulator updates on the same edge as the write stage, so its
   // register is already the cumulative value for the bin being written.
   assign m3WriteVal  = {{(DATA_W-CUM_W){1'b0}}, cum};
   assign m3WE        = we_q;
   assign done        = (state_q == ST_DONE);

endmodule

// File: tb/tb_cdf_pipeline.sv
// tb/tb_cdf_pipeline.sv - self-checking bench for cdf_pipeline
module tb_cdf_pipeline;

   localparam int          NB   = 256;
   localparam logic [95:0] JUNK = {32'hDEAD_BEEF, 32'h1234_5678, 32'hA5A5_5A5A};

   logic         clock = 1'b0;
   logic         rst = 1'b1;
   logic         start = 1'b0;
   logic         inputBaseOffset = 1'b0;
   logic [15:0]  m2ReadAddr, m3WriteAddr, cdfMin, pixelTotal;
   logic [127:0] m2ReadVal = '0;
   logic [127:0] m3WriteVal;
   logic         m3WE, done;

   logic [31:0] mem [0:511];
   logic [15:0] model_cum [0:NB-1];
   logic [15:0] run_val [0:NB-1];
   logic [15:0] prev_val [0:NB-1];

   int n_checks = 0;
   int n_fail   = 0;

   typedef struct {
      int          pattern;
      logic        bank;
      logic [15:0] w0, w1, w10, w200, w255, mn, tot;
   } vec_t;

   vec_t vecs [5];

   cdf_pipeline dut (
      .clock           (clock),
      .rst             (rst),
      .start           (start),
      .inputBaseOffset (inputBaseOffset),
      .m2ReadAddr      (m2ReadAddr),
      .m2ReadVal       (m2ReadVal),
      .m3WriteAddr     (m3WriteAddr),
      .m3WriteVal      (m3WriteVal),
      .m3WE            (m3WE),
      .cdfMin          (cdfMin),
      .pixelTotal      (pixelTotal),
      .done            (done)
   );

   always #5 clock = ~clock;

   // Scratchpad: one-cycle read latency, junk in the ignored upper bits.
   always @(posedge clock) m2ReadVal <= {JUNK, mem[m2ReadAddr[8:0]]};

   function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endfunction

   function automatic logic [15:0] exp_addr(input logic bank, input int k);
      logic [7:0] b;
      b = 8'(k);
      return {7'b0, bank, b};
   endfunction

   task automatic fill_mem(input int pattern, input logic bank);
      logic [31:0] w;
      logic [15:0] sum;
      for (int a = 0; a < 512; a++) mem[a] = {16'hAAAA, 16'h0100};
      for (int k = 0; k < NB; k++) begin
         case (pattern)
            0: w = {16'hAAAA, 16'h0001};
            1: w = (k == 10) ? {16'hAAAA, 16'h0005} :
                   (k == 200) ? {16'hAAAA, 16'h0003} : {16'h0000, 16'(k)};
            2: w = (k == 0) ? {16'hAAAA, 16'h0007} : 32'h0;
            3: w = (k == 0) ? {16'hAAAA, 16'hFFFF} :
                   (k == 1) ? {16'hAAAA, 16'h0002} : 32'h0;
            default: w = {16'hAAAA, 16'h0000};
         endcase
         mem[{bank, 8'(k)}] = w;
      end
      sum = '0;
      for (int k = 0; k < NB; k++) begin
         w = mem[{bank, 8'(k)}];
         if (w[31:16] == 16'hAAAA) sum = sum + w[15:0];
         model_cum[k] = sum;
      end
   endtask

   task automatic do_run(input vec_t v, input int hold_extra);
      int wr, addr_err, wr_err, done_err;
      wr = 0; addr_err = 0; wr_err = 0; done_err = 0;
      for (int k = 0; k < NB; k++) run_val[k] = 16'hDEAD;
      inputBaseOffset = v.bank;
      start = 1'b1;
      @(posedge clock);
      for (int n = 1; n <= NB + 3 + hold_extra; n++) begin
         @(negedge clock);
         if (n <= NB && m2ReadAddr !== exp_addr(v.bank, n - 1)) addr_err++;
         if (m3WE === 1'b1) begin
            if (wr < NB) begin
               run_val[wr] = m3WriteVal[15:0];
               if (m3WriteAddr !== exp_addr(v.bank, wr) ||
                   m3WriteVal !== {112'b0, model_cum[wr]} || n != wr + 3) wr_err++;
            end
            wr++;
         end else if (m3WE !== 1'b0) begin
            wr_err++;
         end
         if (done !== (n >= NB + 3)) done_err++;
      end
      check("rd_addr_seq", addr_err, 0);
      check("wr_count", wr, NB);
      check("wr_seq_vs_model", wr_err, 0);
      check("done_window", done_err, 0);
      check("w0", {16'h0, run_val[0]}, {16'h0, v.w0});
      check("w1", {16'h0, run_val[1]}, {16'h0, v.w1});
      check("w10", {16'h0, run_val[10]}, {16'h0, v.w10});
      check("w200", {16'h0, run_val[200]}, {16'h0, v.w200});
      check("w255", {16'h0, run_val[255]}, {16'h0, v.w255});
      check("cdfMin", {16'h0, cdfMin}, {16'h0, v.mn});
      check("pixelTotal", {16'h0, pixelTotal}, {16'h0, v.tot});
      start = 1'b0;
      @(negedge clock);
      check("done_low_after_start_low", {31'h0, done}, 0);
      check("no_we_in_idle", {31'h0, m3WE}, 0);
      check("min_held_in_idle", {16'h0, cdfMin}, {16'h0, v.mn});
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, "_m2ReadAddr"}, {16'h0, m2ReadAddr}, 0);
      check({tag, "_m3WriteAddr"}, {16'h0, m3WriteAddr}, 0);
      check({tag, "_m3WriteVal_lo"}, m3WriteVal[31:0], 0);
      check({tag, "_m3WE_done"}, {30'h0, m3WE, done}, 0);
      check({tag, "_min_total"}, {cdfMin, pixelTotal}, 0);
   endtask

   initial begin
      int we_seen;
      vecs[0] = '{0, 1'b0, 16'h0001, 16'h0002, 16'h000B, 16'h00C9, 16'h0100, 16'h0001, 16'h0100};
      vecs[1] = '{1, 1'b0, 16'h0000, 16'h0000, 16'h0005, 16'h0008, 16'h0008, 16'h0005, 16'h0008};
      vecs[2] = '{2, 1'b1, 16'h0007, 16'h0007, 16'h0007, 16'h0007, 16'h0007, 16'h0007, 16'h0007};
      vecs[3] = '{3, 1'b0, 16'hFFFF, 16'h0001, 16'h0001, 16'h0001, 16'h0001, 16'hFFFF, 16'h0001};
      vecs[4] = '{4, 1'b0, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000};

      for (int a = 0; a < 512; a++) mem[a] = 32'h0;
      repeat (2) @(posedge clock);
      @(negedge clock);
      check_all_zero("reset");
      rst = 1'b0;

      // Table-driven runs; the first holds start high well past done.
      for (int i = 0; i < 5; i++) begin
         fill_mem(vecs[i].pattern, vecs[i].bank);
         do_run(vecs[i], (i == 0) ? 12 : 0);
         if (i == 0) for (int k = 0; k < NB; k++) prev_val[k] = run_val[k];
      end

      // Repeat run gives identical results.
      fill_mem(0, 1'b0);
      do_run(vecs[0], 0);
      we_seen = 0;
      for (int k = 0; k < NB; k++) if (run_val[k] !== prev_val[k]) we_seen++;
      check("rerun_identical", we_seen, 0);

      // Reset in cycle 100 of a run.
      fill_mem(0, 1'b0);
      inputBaseOffset = 1'b0;
      start = 1'b1;
      @(posedge clock);
      for (int n = 1; n <= 100; n++) @(negedge clock);
      check("pre_rst_we_active", {31'h0, m3WE}, 1);
      rst = 1'b1;
      #1;
      check_all_zero("midrun_rst");
      start = 1'b0;
      @(posedge clock);
      @(negedge clock);
      rst = 1'b0;
      we_seen = 0;
      for (int n = 0; n < 6; n++) begin
         @(negedge clock);
         if (m3WE !== 1'b0 || done !== 1'b0) we_seen++;
      end
      check("no_we_after_rst", we_seen, 0);
      do_run(vecs[0], 0);
      we_seen = 0;
      for (int k = 0; k < NB; k++) if (run_val[k] !== prev_val[k]) we_seen++;
      check("clean_run_after_rst", we_seen, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
